// File: rtl/fifo_rd_stream_if.sv
// Bundle of the FIFO read-port and output-stream signals of fifo_rd_stream.
// master is the streamer's view, slave is the FIFO/consumer side.
interface fifo_rd_stream_if #(
  parameter int WIDTH = 8
);
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_empty;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_cnt;

  modport master (
    output rd_en,
    input  rd_data,
    input  rd_empty,
    output out_data,
    output out_valid,
    input  out_ready,
    output out_cnt
  );

  modport slave (
    input  rd_en,
    output rd_data,
    output rd_empty,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  out_cnt
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Turns a 1-cycle-latency FIFO read port into a valid/ready stream through a
// 2-entry in-order skid buffer, counting completed transfers.
module fifo_rd_stream #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  fifo_rd_stream_if.master   bus
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  occ_e             occ_q;
  logic             inflight_q;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic [15:0]      cnt_q;

  logic             pop_s;
  logic             capture_s;
  logic [1:0]       pending_s;
  logic             rd_en_s;

  // Pop/capture decode and read request; pending_s is the buffer load after this edge minus new reads.
  always_comb begin
    pop_s     = (occ_q != OCC_EMPTY) & bus.out_ready;
    capture_s = inflight_q;
    pending_s = occ_q + {1'b0, inflight_q} - {1'b0, pop_s};
    rd_en_s   = ~rst & ~bus.rd_empty & (pending_s < 2'd2);
  end

  // Occupancy FSM with head/tail storage, in-flight tracking and transfer count.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q      <= OCC_EMPTY;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= 16'd0;
    end else begin
      inflight_q <= rd_en_s;
      if (pop_s) begin
        cnt_q <= cnt_q + 16'd1;
      end
      case (occ_q)
        OCC_EMPTY: begin
          if (capture_s) begin
            head_q <= bus.rd_data;
            occ_q  <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (capture_s && pop_s) begin
            head_q <= bus.rd_data;
          end else if (capture_s) begin
            tail_q <= bus.rd_data;
            occ_q  <= OCC_TWO;
          end else if (pop_s) begin
            // head reads zero whenever the buffer is empty
            head_q <= '0;
            occ_q  <= OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          // a capture here always coincides with a pop: rd_en is withheld at full load
          if (pop_s) begin
            head_q <= tail_q;
            if (capture_s) begin
              tail_q <= bus.rd_data;
            end else begin
              occ_q <= OCC_ONE;
            end
          end
        end
        default: begin
          occ_q  <= OCC_EMPTY;
          head_q <= '0;
        end
      endcase
    end
  end

  assign bus.rd_en     = rd_en_s;
  assign bus.out_data  = head_q;
  assign bus.out_valid = (occ_q != OCC_EMPTY);
  assign bus.out_cnt   = cnt_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomised bench for fifo_rd_stream: an upstream FIFO model feeds the DUT,
// a scoreboard queue of released words is checked by an independent monitor.
module tb_fifo_rd_stream;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_rd_stream_if #(.WIDTH(WIDTH)) bif ();
  fifo_rd_stream #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bif));

  logic [WIDTH-1:0] src_q[$];   // words still waiting in the upstream FIFO
  logic [WIDTH-1:0] exp_q[$];   // words released to the DUT, not yet delivered
  int total = 0;
  int bad = 0;
  int mcnt = 0;
  int rden_pulses = 0;
  logic pend = 1'b0;
  logic infl = 1'b0;
  logic [WIDTH-1:0] pend_word = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
    end
  endtask

  // One cycle: drive inputs at negedge, check against the word-level model, follow rd_en.
  task automatic step(input logic r, input logic rdy);
    int   occ_m;
    logic pop_m;
    logic exp_rd;
    @(negedge clk);
    rst           = r;
    bif.out_ready = rdy;
    bif.rd_data   = pend ? pend_word : WIDTH'($urandom);
    infl          = pend;
    bif.rd_empty  = (src_q.size() == 0);
    #1;
    if (r) begin
      chk("rd_en_in_reset", {31'd0, bif.rd_en}, 32'd0);
      exp_q.delete();
      pend = 1'b0;
    end else begin
      occ_m = exp_q.size() - int'(infl);
      chk("occupancy_bound", {31'd0, (exp_q.size() <= 2)}, 32'd1);
      pop_m = (occ_m > 0) && rdy;
      chk("out_valid", {31'd0, bif.out_valid}, {31'd0, (occ_m > 0)});
      chk("out_data", {24'd0, bif.out_data}, (occ_m > 0) ? {24'd0, exp_q[0]} : 32'd0);
      exp_rd = !bif.rd_empty && ((exp_q.size() - int'(pop_m)) < 2);
      chk("rd_en", {31'd0, bif.rd_en}, {31'd0, exp_rd});
      if (bif.rd_en === 1'b1 && src_q.size() != 0) begin
        pend_word = src_q.pop_front();
        exp_q.push_back(pend_word);
        pend = 1'b1;
        rden_pulses++;
      end else begin
        pend = 1'b0;
      end
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      step(1'b0, 1'b1);
      n++;
    end
    chk("drain_done", src_q.size() + exp_q.size(), 32'd0);
  endtask

  // Monitor: pops the scoreboard on every accepted transfer and tracks the count.
  initial begin
    logic [WIDTH-1:0] w;
    forever begin
      @(negedge clk);
      #2;
      if (rst !== 1'b0) begin
        mcnt = 0;
      end else begin
        chk("out_cnt", {16'd0, bif.out_cnt}, mcnt & 32'h0000_FFFF);
        if (bif.out_valid === 1'b1 && bif.out_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_transfer", exp_q.size(), 32'd1);
          end else begin
            w = exp_q.pop_front();
            chk("transfer_data", {24'd0, bif.out_data}, {24'd0, w});
          end
          mcnt++;
        end
      end
    end
  end

  initial begin
    int n;
    rst           = 1'b1;
    bif.out_ready = 1'b0;
    bif.rd_empty  = 1'b1;
    bif.rd_data   = '0;
    repeat (3) step(1'b1, 1'b0);

    // fill and drain
    for (int i = 1; i <= 10; i++) src_q.push_back(WIDTH'(i));
    drain(40);
    chk("fill_cnt", {16'd0, bif.out_cnt}, 32'd10);

    // backpressure
    for (int i = 1; i <= 5; i++) src_q.push_back(WIDTH'(i));
    rden_pulses = 0;
    repeat (10) step(1'b0, 1'b0);
    chk("bp_rd_en_pulses", rden_pulses, 32'd2);
    chk("bp_head", {24'd0, bif.out_data}, 32'h01);
    drain(40);

    // empty upstream
    rden_pulses = 0;
    repeat (20) step(1'b0, 1'b1);
    chk("empty_rd_en_pulses", rden_pulses, 32'd0);
    src_q.push_back(8'h5A);
    drain(20);
    chk("empty_cnt", {16'd0, bif.out_cnt}, 32'd16);

    // alternating ready
    for (int i = 0; i < 8; i++) src_q.push_back(WIDTH'($urandom));
    for (int i = 0; i < 40; i++) step(1'b0, (i % 2) == 0);
    drain(20);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0 && src_q.size() < 6) src_q.push_back(WIDTH'($urandom));
      step(1'b0, $urandom_range(0, 3) != 0);
    end
    drain(100);

    // reset mid-stream with a word in flight
    for (int i = 0; i < 6; i++) src_q.push_back(WIDTH'($urandom));
    repeat (3) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    drain(40);

    // counter wrap
    n = 0;
    while (mcnt < 65539 && n < 70000) begin
      if (src_q.size() < 3) src_q.push_back(WIDTH'($urandom));
      step(1'b0, 1'b1);
      n++;
    end
    chk("wrap_reached", {31'd0, (mcnt >= 65539)}, 32'd1);
    drain(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
